framebuffer_tile: RTL

- On-chip color tile buffer sitting directly downstream of the pixel pipeline.
- Serves its per-fragment color read port (1-cycle latency) and write port.
- Fills the tile with a clear color on command.
- Streams the tile contents out as an AXI-Stream master for commit to external memory.
- Each command runs as a single-issue FSM, reported via busy.

---
 rtl/framebuffer_tile.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/framebuffer_tile.sv
// ---------------------------------------------------------------------------
// framebuffer_tile
//
// On-chip colour tile buffer placed directly after the pixel pipeline.
//   - Fragment port: registered read (1-cycle latency, old data on a
//     same-address read-during-write) and a write port that is honoured only
//     while the block is idle.
//   - cmdClear fills pixels 0..confSize-1 with confClearColor.
//   - cmdCommit streams pixels 0..confSize-1 (rounded up to whole beats) out
//     as an AXI-Stream master, N = STREAM_WIDTH/PIXEL_WIDTH pixels per beat,
//     lowest address in the LSBs.
//
// Ports:
//   aclk, reset          clock, synchronous active-high reset
//   colorIndexRead       fragment read address  -> colorIn (next cycle)
//   colorIndexWrite      fragment write address, colorWriteEnable, colorOut
//   confClearColor       clear value (sampled at clear start)
//   confSize             pixel count for clear/commit (sampled at start)
//   cmdClear, cmdCommit  1-cycle command pulses (clear wins if both)
//   busy                 high while a command executes
//   m_axis_*             stream master (tvalid, tready, tlast, tdata)
//
// Optional build macro FRAMEBUFFER_WRITE_MASK_EN adds confWriteMask[3:0]:
// one enable per 8-bit-style sub-pixel (bit 3 = most significant sub-pixel)
// applied to fragment writes and to clear writes.
//
// Storage is split into N banks indexed by (address mod N) so one row read
// returns a whole stream beat; every bank has a fragment read port and a
// stream read port, both registered.
// ---------------------------------------------------------------------------
module framebuffer_tile #(
    parameter int FRAMEBUFFER_INDEX_WIDTH = 14,
    parameter int PIXEL_WIDTH             = 32,
    parameter int STREAM_WIDTH            = 64
) (
    input  logic                               aclk,
    input  logic                               reset,
    input  logic [FRAMEBUFFER_INDEX_WIDTH-1:0] colorIndexRead,
    output logic [PIXEL_WIDTH-1:0]             colorIn,
    input  logic [FRAMEBUFFER_INDEX_WIDTH-1:0] colorIndexWrite,
    input  logic                               colorWriteEnable,
    input  logic [PIXEL_WIDTH-1:0]             colorOut,
    input  logic [PIXEL_WIDTH-1:0]             confClearColor,
    input  logic [FRAMEBUFFER_INDEX_WIDTH:0]   confSize,
`ifdef FRAMEBUFFER_WRITE_MASK_EN
    input  logic [3:0]                         confWriteMask,
`endif
    input  logic                               cmdClear,
    input  logic                               cmdCommit,
    output logic                               busy,
    output logic                               m_axis_tvalid,
    input  logic                               m_axis_tready,
    output logic                               m_axis_tlast,
    output logic [STREAM_WIDTH-1:0]            m_axis_tdata
);
    localparam int AW         = FRAMEBUFFER_INDEX_WIDTH;
    localparam int N          = STREAM_WIDTH / PIXEL_WIDTH;
    localparam int SUB_W      = PIXEL_WIDTH / 4;
    localparam int TILE_DEPTH = 2 ** AW;
    localparam int ROWS       = (TILE_DEPTH + N - 1) / N;
    localparam int ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int BSEL_W     = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CLEAR, STREAM, DRAIN} state_t;

    state_t                   state_q, state_d;
    logic                     busy_q, busy_d;
    logic [AW:0]              size_q, size_d;
    logic [AW:0]              cnt_q, cnt_d;        // clear address / stream row
    logic [PIXEL_WIDTH-1:0]   clear_color_q, clear_color_d;
    logic                     inflight_q, inflight_d;
    logic                     inflight_last_q, inflight_last_d;
    logic [1:0]               fifo_cnt_q, fifo_cnt_d;
    logic [STREAM_WIDTH-1:0]  fifo_data0_q, fifo_data0_d, fifo_data1_q, fifo_data1_d;
    logic                     fifo_last0_q, fifo_last0_d, fifo_last1_q, fifo_last1_d;
    logic [BSEL_W-1:0]        rd_bank_q, rd_bank_d;

    logic                     wr_en;
    logic [AW-1:0]            wr_addr;
    logic [PIXEL_WIDTH-1:0]   wr_data;
    logic [3:0]               wr_mask;
    logic [ROW_W-1:0]         wr_row, rd_row, stream_row;
    logic [BSEL_W-1:0]        wr_bank;
    logic [AW:0]              beats, last_row;
    logic [2:0]               occ;
    logic                     pop, push, issue;
    logic [STREAM_WIDTH-1:0]  stream_rd;
    logic [N*PIXEL_WIDTH-1:0] frag_rd_all;

`ifdef FRAMEBUFFER_WRITE_MASK_EN
    assign wr_mask = confWriteMask;
`else
    assign wr_mask = 4'hF;
`endif

    // Single write port shared by fragment writes (idle only) and clear.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = colorIndexWrite;
        wr_data = colorOut;
        if (state_q == IDLE && colorWriteEnable) begin
            wr_en = 1'b1;
        end else if (state_q == CLEAR && cnt_q < size_q) begin
            wr_en   = 1'b1;
            wr_addr = cnt_q[AW-1:0];
            wr_data = clear_color_q;
        end
    end

    assign wr_row     = ROW_W'(wr_addr / N);
    assign wr_bank    = BSEL_W'(wr_addr % N);
    assign rd_row     = ROW_W'(colorIndexRead / N);
    assign rd_bank_d  = BSEL_W'(colorIndexRead % N);
    assign stream_row = cnt_q[ROW_W-1:0];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_bank
            logic [PIXEL_WIDTH-1:0] mem [ROWS];
            logic [PIXEL_WIDTH-1:0] frag_rd_q;
            logic [PIXEL_WIDTH-1:0] stream_rd_q;
            logic                   bank_we;

            assign bank_we = wr_en && (wr_bank == BSEL_W'(gi));

            always_ff @(posedge aclk) begin
                for (int k = 0; k < 4; k++) begin
                    if (bank_we && wr_mask[k]) begin
                        mem[wr_row][k*SUB_W +: SUB_W] <= wr_data[k*SUB_W +: SUB_W];
                    end
                end
                if (reset) begin
                    frag_rd_q   <= '0;
                    stream_rd_q <= '0;
                end else begin
                    frag_rd_q <= mem[rd_row];
                    if (issue) begin
                        stream_rd_q <= mem[stream_row];
                    end
                end
            end

            assign frag_rd_all[gi*PIXEL_WIDTH +: PIXEL_WIDTH] = frag_rd_q;
            assign stream_rd[gi*PIXEL_WIDTH +: PIXEL_WIDTH]   = stream_rd_q;
        end
    endgenerate

    assign colorIn = frag_rd_all[rd_bank_q*PIXEL_WIDTH +: PIXEL_WIDTH];

    // Stream side: the skid FIFO plus the read in flight may never exceed two
    // beats, which keeps one beat per cycle under tready=1 without overflow.
    assign beats    = (AW+1)'((32'(size_q) + N - 1) / N);
    assign last_row = beats - 1'b1;
    assign pop      = (fifo_cnt_q != 2'd0) && m_axis_tready;
    assign push     = inflight_q;
    assign occ      = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue    = (state_q == STREAM) && (occ < 3'd2);

    always_comb begin
        state_d         = state_q;
        size_d          = size_q;
        cnt_d           = cnt_q;
        clear_color_d   = clear_color_q;
        inflight_d      = issue;
        inflight_last_d = issue && (cnt_q == last_row);
        case (state_q)
            IDLE: begin
                if (cmdClear) begin
                    state_d       = CLEAR;
                    cnt_d         = '0;
                    size_d        = confSize;
                    clear_color_d = confClearColor;
                end else if (cmdCommit) begin
                    cnt_d  = '0;
                    size_d = confSize;
                    // An empty commit reuses the write-free one-cycle CLEAR pass.
                    state_d = (confSize == '0) ? CLEAR : STREAM;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q + 1'b1 >= size_q) begin
                    state_d = IDLE;
                end
            end
            STREAM: begin
                if (issue) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == last_row) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && fifo_last0_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Two-entry skid FIFO; entry 0 is the head presented on m_axis.
    always_comb begin
        fifo_cnt_d   = fifo_cnt_q;
        fifo_data0_d = fifo_data0_q;
        fifo_data1_d = fifo_data1_q;
        fifo_last0_d = fifo_last0_q;
        fifo_last1_d = fifo_last1_q;
        case ({push, pop})
            2'b10: begin
                if (fifo_cnt_q == 2'd0) begin
                    fifo_data0_d = stream_rd;
                    fifo_last0_d = inflight_last_q;
                end else begin
                    fifo_data1_d = stream_rd;
                    fifo_last1_d = inflight_last_q;
                end
                fifo_cnt_d = fifo_cnt_q + 2'd1;
            end
            2'b01: begin
                fifo_data0_d = fifo_data1_q;
                fifo_last0_d = fifo_last1_q;
                fifo_cnt_d   = fifo_cnt_q - 2'd1;
            end
            2'b11: begin
                if (fifo_cnt_q == 2'd1) begin
                    fifo_data0_d = stream_rd;
                    fifo_last0_d = inflight_last_q;
                end else begin
                    fifo_data0_d = fifo_data1_q;
                    fifo_last0_d = fifo_last1_q;
                    fifo_data1_d = stream_rd;
                    fifo_last1_d = inflight_last_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            state_q         <= IDLE;
            busy_q          <= 1'b0;
            size_q          <= '0;
            cnt_q           <= '0;
            clear_color_q   <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            fifo_cnt_q      <= 2'd0;
            fifo_data0_q    <= '0;
            fifo_data1_q    <= '0;
            fifo_last0_q    <= 1'b0;
            fifo_last1_q    <= 1'b0;
            rd_bank_q       <= '0;
        end else begin
            state_q         <= state_d;
            busy_q          <= busy_d;
            size_q          <= size_d;
            cnt_q           <= cnt_d;
            clear_color_q   <= clear_color_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            fifo_cnt_q      <= fifo_cnt_d;
            fifo_data0_q    <= fifo_data0_d;
            fifo_data1_q    <= fifo_data1_d;
            fifo_last0_q    <= fifo_last0_d;
            fifo_last1_q    <= fifo_last1_d;
            rd_bank_q       <= rd_bank_d;
        end
    end

    assign busy          = busy_q;
    assign m_axis_tvalid = (fifo_cnt_q != 2'd0);
    assign m_axis_tlast  = m_axis_tvalid && fifo_last0_q;
    assign m_axis_tdata  = fifo_data0_q;

endmodule
